// File: rtl/fib_scheduler_if.sv
// Handshake bundle between fib_scheduler, its requesters and the shared Fibonacci core.
// The scheduler uses the slave modport; the requester/core side uses master.
interface fib_scheduler_if #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_REQ    = 4
);
    localparam int FW = 2*DATA_WIDTH+2;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_n;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ*FW-1:0]         rsp_f;
    logic [NUM_REQ-1:0]            rsp_err;
    logic [NUM_REQ-1:0]            rsp_ack;
    logic                          core_start;
    logic [DATA_WIDTH-1:0]         core_n;
    logic                          core_done;
    logic [FW-1:0]                 core_f;
    logic                          busy;

    modport master (
        output req_valid, req_n, rsp_ack, core_done, core_f,
        input  req_ready, rsp_valid, rsp_f, rsp_err, core_start, core_n, busy
    );

    modport slave (
        input  req_valid, req_n, rsp_ack, core_done, core_f,
        output req_ready, rsp_valid, rsp_f, rsp_err, core_start, core_n, busy
    );
endinterface

// File: rtl/fib_scheduler.sv
// Round-robin scheduler that shares one Fibonacci core among NUM_REQ requesters,
// with per-requester held responses and a watchdog on the core's completion.
module fib_scheduler #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic          clk,
    input  logic          rst,
    fib_scheduler_if.slave bus
);
    localparam int FW = 2*DATA_WIDTH+2;
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT+1);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           grant_q, grant_d;
    logic [IW-1:0]           last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0]   core_n_q, core_n_d;
    logic                    core_start_q, core_start_d;
    logic                    busy_q, busy_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0]      rsp_err_q, rsp_err_d;
    logic [NUM_REQ*FW-1:0]   rsp_f_q, rsp_f_d;
    logic [NUM_REQ-1:0]      req_ready_c;
    logic [NUM_REQ-1:0]      eligible;
    logic                    found;
    logic [IW-1:0]           pick;
    logic [IW-1:0]           cand;

    // A requester with an unconsumed response is held off until it acks.
    assign eligible = bus.req_valid & ~rsp_valid_q;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(last_grant_q) + k) % NUM_REQ);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        core_n_d     = core_n_q;
        core_start_d = 1'b0;
        busy_d       = busy_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = rsp_valid_q & ~bus.rsp_ack;
        rsp_err_d    = rsp_err_q;
        rsp_f_d      = rsp_f_q;
        req_ready_c  = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready_c[pick] = 1'b1;
                    grant_d           = pick;
                    core_n_d          = bus.req_n[pick*DATA_WIDTH +: DATA_WIDTH];
                    core_start_d      = 1'b1;
                    busy_d            = 1'b1;
                    state_d           = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A completion landing on the last watchdog cycle still counts as success.
                if (bus.core_done || cnt_q == CW'(TIMEOUT-1)) begin
                    rsp_valid_d[grant_q]        = 1'b1;
                    rsp_err_d[grant_q]          = !bus.core_done;
                    rsp_f_d[grant_q*FW +: FW]   = bus.core_done ? bus.core_f : {FW{1'b1}};
                    last_grant_d                = grant_q;
                    busy_d                      = 1'b0;
                    cnt_d                       = '0;
                    state_d                     = IDLE;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IW'(NUM_REQ-1);
            core_n_q     <= '0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_err_q    <= '0;
            rsp_f_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            core_n_q     <= core_n_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_f_q      <= rsp_f_d;
        end
    end

    assign bus.req_ready  = rst ? '0 : req_ready_c;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_f      = rsp_f_q;
    assign bus.core_start = core_start_q;
    assign bus.core_n     = core_n_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_fib_scheduler.sv
// Self-checking bench for fib_scheduler: directed scenarios plus randomized traffic
// checked against a transaction-level model of arbitration, responses and the core.
module tb_fib_scheduler;
    localparam int DW = 4;
    localparam int NR = 4;
    localparam int TO = 64;
    localparam int FW = 2*DW+2;
    localparam int NW = NR*DW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fib_scheduler_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus();

    fib_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [NR-1:0] m_pend;
    logic [FW-1:0] m_f [NR];
    bit            m_err [NR];
    int            m_last;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] fib(input int n);
        int a = 0;
        int b = 1;
        int t;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return FW'(a);
    endfunction

    // Next requester after the last served one, skipping those with unconsumed results.
    function automatic int modelGrant(input logic [NR-1:0] valid);
        for (int k = 1; k <= NR; k++) begin
            if (valid[(m_last + k) % NR] && !m_pend[(m_last + k) % NR])
                return (m_last + k) % NR;
        end
        return -1;
    endfunction

    task automatic checkRsp();
        checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(m_pend));
        for (int i = 0; i < NR; i++) begin
            if (m_pend[i]) begin
                checkOutput($sformatf("rsp_f[%0d]", i), 64'(bus.rsp_f[i*FW +: FW]), 64'(m_f[i]));
                checkOutput($sformatf("rsp_err[%0d]", i), 64'(bus.rsp_err[i]), 64'(m_err[i]));
            end
        end
    endtask

    task automatic doReset();
        rst            = 1'b1;
        bus.req_valid  = '1;
        bus.rsp_ack    = '0;
        bus.core_done  = 1'b0;
        #1;
        checkOutput("rst_req_ready", 64'(bus.req_ready), 64'(0));
        checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        checkOutput("rst_rsp_err", 64'(bus.rsp_err), 64'(0));
        checkOutput("rst_rsp_f", 64'(bus.rsp_f), 64'(0));
        checkOutput("rst_core_start", 64'(bus.core_start), 64'(0));
        checkOutput("rst_core_n", 64'(bus.core_n), 64'(0));
        checkOutput("rst_busy", 64'(bus.busy), 64'(0));
        @(negedge clk);
        bus.req_valid = '0;
        rst           = 1'b0;
        m_pend        = '0;
        m_last        = NR-1;
    endtask

    // One idle cycle of offers/acks; if a grant happens, run the whole transaction.
    // lat = WAIT cycle on which the core completes (0 = never, forcing the watchdog).
    task automatic applyStimulus(input logic [NR-1:0] valid, input logic [NW-1:0] ns,
                                 input logic [NR-1:0] ack, input int lat, output int g);
        logic [NR-1:0] expReady;
        logic [DW-1:0] n;
        bit            done;
        bus.req_valid = valid;
        bus.req_n     = ns;
        bus.rsp_ack   = ack;
        #1;
        g        = modelGrant(valid);
        expReady = '0;
        if (g >= 0) expReady[g] = 1'b1;
        checkOutput("req_ready", 64'(bus.req_ready), 64'(expReady));
        checkOutput("busy_idle", 64'(bus.busy), 64'(0));
        checkOutput("core_start_idle", 64'(bus.core_start), 64'(0));
        checkRsp();
        @(posedge clk);
        m_pend &= ~ack;
        @(negedge clk);
        bus.rsp_ack = '0;
        if (g < 0) return;

        n             = ns[g*DW +: DW];
        bus.req_valid = NR'($urandom);
        bus.req_n     = NW'($urandom);
        #1;
        checkOutput("core_start", 64'(bus.core_start), 64'(1));
        checkOutput("core_n_start", 64'(bus.core_n), 64'(n));
        checkOutput("busy_start", 64'(bus.busy), 64'(1));
        checkOutput("req_ready_start", 64'(bus.req_ready), 64'(0));
        @(posedge clk);
        @(negedge clk);
        for (int w = 1; w <= TO; w++) begin
            done          = (w == lat);
            bus.core_done = done;
            bus.core_f    = done ? fib(int'(n)) : FW'($urandom);
            #1;
            checkOutput("core_start_wait", 64'(bus.core_start), 64'(0));
            checkOutput("core_n_wait", 64'(bus.core_n), 64'(n));
            checkOutput("busy_wait", 64'(bus.busy), 64'(1));
            checkOutput("req_ready_wait", 64'(bus.req_ready), 64'(0));
            checkOutput("rsp_valid_wait", 64'(bus.rsp_valid[g]), 64'(0));
            @(posedge clk);
            @(negedge clk);
            bus.core_done = 1'b0;
            if (done) break;
        end
        m_pend[g]     = 1'b1;
        m_err[g]      = (lat < 1 || lat > TO);
        m_f[g]        = m_err[g] ? {FW{1'b1}} : fib(int'(n));
        m_last        = g;
        bus.req_valid = '0;
    endtask

    initial begin
        int g;
        int r;
        int lat;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_n     = '0;
        bus.rsp_ack   = '0;
        bus.core_done = 1'b0;
        bus.core_f    = '0;
        m_pend        = '0;
        m_last        = NR-1;
        for (int i = 0; i < NR; i++) begin
            m_f[i]   = '0;
            m_err[i] = 1'b0;
        end
        @(negedge clk);
        doReset();

        $display("[TB] single request");
        applyStimulus(4'b0001, 16'h0005, 4'b0000, 3, g);
        checkOutput("single_grant", 64'(g), 64'(0));
        applyStimulus(4'b0000, 16'h0000, 4'b0001, 1, g);
        applyStimulus(4'b0000, 16'h0000, 4'b0000, 1, g);

        $display("[TB] timeout with late core_done");
        applyStimulus(4'b0010, NW'($urandom), 4'b0000, 0, g);
        checkOutput("timeout_grant", 64'(g), 64'(1));
        bus.core_done = 1'b1;
        bus.core_f    = FW'($urandom);
        applyStimulus(4'b0000, 16'h0000, 4'b0000, 1, g);
        bus.core_done = 1'b0;
        applyStimulus(4'b0000, 16'h0000, 4'b0000, 1, g);

        $display("[TB] reset during WAIT");
        bus.req_valid = 4'b0100;
        bus.req_n     = NW'($urandom);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("busy_pre_rst", 64'(bus.busy), 64'(1));
        doReset();
        applyStimulus(4'b1111, NW'($urandom), 4'b0000, 2, g);
        checkOutput("grant_after_rst", 64'(g), 64'(0));

        $display("[TB] round robin");
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1111, NW'($urandom), m_pend, 2, g);
            checkOutput($sformatf("rr_order_%0d", i), 64'(g), 64'(i % NR));
        end

        $display("[TB] pending response blocks re-grant");
        doReset();
        applyStimulus(4'b0100, NW'($urandom), 4'b0000, 2, g);
        checkOutput("pend_first", 64'(g), 64'(2));
        applyStimulus(4'b1100, NW'($urandom), 4'b0000, 2, g);
        checkOutput("pend_other", 64'(g), 64'(3));
        applyStimulus(4'b0100, NW'($urandom), 4'b0000, 2, g);
        checkOutput("pend_blocked", 64'(g), 64'(-1));
        applyStimulus(4'b0100, NW'($urandom), 4'b0100, 2, g);
        checkOutput("pend_ack_cycle", 64'(g), 64'(-1));
        applyStimulus(4'b0100, NW'($urandom), 4'b0000, 2, g);
        checkOutput("pend_regrant", 64'(g), 64'(2));

        $display("[TB] index boundaries");
        doReset();
        applyStimulus(4'b0001, 16'h0000, 4'b0000, 1, g);
        applyStimulus(4'b0010, 16'h0010, 4'b0000, 4, g);
        applyStimulus(4'b0100, 16'h0F00, 4'b0000, TO, g);
        applyStimulus(4'b0000, 16'h0000, 4'b0000, 1, g);
        checkOutput("fib15", 64'(bus.rsp_f[2*FW +: FW]), 64'(610));

        $display("[TB] randomized traffic");
        for (int t = 0; t < 200; t++) begin
            r   = $urandom_range(0, 15);
            lat = (r == 0) ? 0 : (r == 1) ? TO : $urandom_range(1, 6);
            applyStimulus(NR'($urandom), NW'($urandom), NR'($urandom), lat, g);
        end
        applyStimulus(4'b0000, 16'h0000, 4'b0000, 1, g);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
